// File: rtl/video_scan_counter_pkg.sv
// Shared raster constants for the Apple II video scan counter chain.
// Other video blocks import these bounds so that blanking and sync stay consistent.
package video_scan_counter_pkg;

  localparam logic [6:0] HPreset   = 7'h40;
  localparam logic [6:0] HLast     = 7'h7F;
  localparam logic [6:0] HVisLo    = 7'h58;
  localparam logic [6:0] HSyncLo   = 7'h48;
  localparam logic [8:0] VPreset60 = 9'h0FA;
  localparam logic [8:0] VPreset50 = 9'h0C8;
  localparam logic [8:0] VLast     = 9'h1FF;
  localparam logic [8:0] VSyncLo   = 9'h1E0;

  localparam int unsigned SyncWidth   = 4;
  localparam int unsigned LineStates  = 65;
  localparam int unsigned FrameLines  = 262;

  // True when val lies in the SyncWidth-wide window starting at lo.
  // Both values are widened by one bit so that lo + width cannot wrap.
  function automatic logic in_sync_window(input logic [8:0] val, input logic [8:0] lo);
    logic [9:0] val_w;
    logic [9:0] lo_w;
    val_w = {1'b0, val};
    lo_w  = {1'b0, lo};
    return (val_w >= lo_w) && (val_w < (lo_w + 10'(SyncWidth)));
  endfunction

endpackage

// File: rtl/video_scan_counter_hcount.sv
// Horizontal scan counter: 00 -> preset -> ... -> 7F -> 00, i.e. 65 states per line.
// Exposes its next state so that the top level can register the decodes without latency.
module video_scan_counter_hcount
  import video_scan_counter_pkg::*;
#(
  parameter logic [6:0] H_PRESET = HPreset
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cnt_en_i,
  output logic [6:0] h_o,
  output logic [6:0] h_next_o,
  output logic       wrap_o
);

  logic [6:0] h_q;
  logic [6:0] h_d;

  // Any value below the preset, the legal 00 state included, is redirected to the preset.
  always_comb begin
    h_d = h_q;
    if (cnt_en_i) begin
      if (h_q == HLast) begin
        h_d = 7'h00;
      end else if (h_q < H_PRESET) begin
        h_d = H_PRESET;
      end else begin
        h_d = h_q + 7'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      h_q <= 7'h00;
    end else begin
      h_q <= h_d;
    end
  end

  assign h_o      = h_q;
  assign h_next_o = h_d;
  assign wrap_o   = cnt_en_i && (h_q == HLast);

endmodule

// File: rtl/video_scan_counter.sv
// Apple II H/V raster counter chain with registered blank/sync decodes and line/frame strobes.
// The decodes are taken from the next state, so they change on the same edge as H and V.
module video_scan_counter
  import video_scan_counter_pkg::*;
#(
  parameter logic [6:0] H_PRESET = HPreset,
  parameter logic [8:0] V_PRESET = VPreset60,
  parameter logic [6:0] HSYNC_LO = HSyncLo,
  parameter logic [8:0] VSYNC_LO = VSyncLo
) (
  input  logic       CP_14M,
  input  logic       CLR,
  input  logic       CNT_EN,
  output logic [6:0] H,
  output logic [8:0] V,
  output logic       HBL,
  output logic       VBL,
  output logic       BLANK,
  output logic       HSYNC,
  output logic       VSYNC,
  output logic       LINE_END,
  output logic       FRAME_END
);

  logic [6:0] h_next;
  logic       h_wrap;
  logic [8:0] v_q, v_d;
  logic       hbl_q, vbl_q, blank_q, hsync_q, vsync_q;
  logic       hbl_d, vbl_d;

  video_scan_counter_hcount #(
    .H_PRESET (H_PRESET)
  ) u_hcount (
    .clk_i    (CP_14M),
    .rst_i    (CLR),
    .cnt_en_i (CNT_EN),
    .h_o      (H),
    .h_next_o (h_next),
    .wrap_o   (h_wrap)
  );

  always_comb begin
    v_d = v_q;
    if (h_wrap) begin
      v_d = (v_q == VLast) ? V_PRESET : v_q + 9'd1;
    end
  end

  assign hbl_d = h_next < HVisLo;
  assign vbl_d = ~v_d[8] | (v_d[7] & v_d[6]);

  // Decodes only load on count strobes so they read 0 after reset until the first count.
  always_ff @(posedge CP_14M or posedge CLR) begin
    if (CLR) begin
      v_q     <= V_PRESET;
      hbl_q   <= 1'b0;
      vbl_q   <= 1'b0;
      blank_q <= 1'b0;
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
    end else begin
      v_q <= v_d;
      if (CNT_EN) begin
        hbl_q   <= hbl_d;
        vbl_q   <= vbl_d;
        blank_q <= hbl_d | vbl_d;
        hsync_q <= in_sync_window({2'b00, h_next}, {2'b00, HSYNC_LO});
        vsync_q <= in_sync_window(v_d, VSYNC_LO);
      end
    end
  end

  assign V         = v_q;
  assign HBL       = hbl_q;
  assign VBL       = vbl_q;
  assign BLANK     = blank_q;
  assign HSYNC     = hsync_q;
  assign VSYNC     = vsync_q;
  assign LINE_END  = h_wrap;
  assign FRAME_END = h_wrap && (v_q == VLast);

endmodule

// File: tb/tb_video_scan_counter.sv
// Self-checking bench: a 60 Hz and a 50 Hz counter share stimulus and are checked against
// a raster-position model (column index within the line, line index within the frame).
module tb_video_scan_counter;

  logic CP_14M = 1'b0;
  logic CLR;
  logic CNT_EN;

  logic [6:0] h60, h50;
  logic [8:0] v60, v50;
  logic hbl60, vbl60, blank60, hs60, vs60, le60, fe60;
  logic hbl50, vbl50, blank50, hs50, vs50, le50, fe50;

  int n_checks = 0;
  int n_errors = 0;

  // Model: pos 0 is the extra H=00 state, pos 1..64 are H=40..7F.
  int  pos, l60, l50;
  bit  counted;
  int  n_cnt, n_le60, n_fe60, n_fe50, n_vis;

  always #5 CP_14M = ~CP_14M;

  video_scan_counter dut60 (
    .CP_14M (CP_14M), .CLR (CLR), .CNT_EN (CNT_EN),
    .H (h60), .V (v60), .HBL (hbl60), .VBL (vbl60), .BLANK (blank60),
    .HSYNC (hs60), .VSYNC (vs60), .LINE_END (le60), .FRAME_END (fe60)
  );

  video_scan_counter #(
    .V_PRESET (9'h0C8)
  ) dut50 (
    .CP_14M (CP_14M), .CLR (CLR), .CNT_EN (CNT_EN),
    .H (h50), .V (v50), .HBL (hbl50), .VBL (vbl50), .BLANK (blank50),
    .HSYNC (hs50), .VSYNC (vs50), .LINE_END (le50), .FRAME_END (fe50)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    pos = 0; l60 = 0; l50 = 0; counted = 0;
    n_cnt = 0; n_le60 = 0; n_fe60 = 0; n_fe50 = 0; n_vis = 0;
  endtask

  function automatic int model_h();
    return (pos == 0) ? 0 : 'h40 + pos - 1;
  endfunction

  task automatic check_one(input string name, input int hv, input int vv,
                           input logic [6:0] h, input logic [8:0] v, input logic hbl,
                           input logic vbl, input logic blank, input logic hs, input logic vs);
    bit e_hbl, e_vbl, e_hs, e_vs;
    e_hbl = counted && (hv < 'h58);
    e_vbl = counted && (vv < 'h100 || vv >= 'h1C0);
    e_hs  = counted && (hv >= 'h48 && hv <= 'h4B);
    e_vs  = counted && (vv >= 'h1E0 && vv <= 'h1E3);
    chk({name, ".H"}, 32'(h), 32'(hv));
    chk({name, ".V"}, 32'(v), 32'(vv));
    chk({name, ".HBL"}, 32'(hbl), 32'(e_hbl));
    chk({name, ".VBL"}, 32'(vbl), 32'(e_vbl));
    chk({name, ".BLANK"}, 32'(blank), 32'(e_hbl | e_vbl));
    chk({name, ".HSYNC"}, 32'(hs), 32'(e_hs));
    chk({name, ".VSYNC"}, 32'(vs), 32'(e_vs));
  endtask

  task automatic check_state();
    check_one("dut60", model_h(), 'h0FA + l60, h60, v60, hbl60, vbl60, blank60, hs60, vs60);
    check_one("dut50", model_h(), 'h0C8 + l50, h50, v50, hbl50, vbl50, blank50, hs50, vs50);
  endtask

  // Called just after a rising edge; drives CNT_EN for the next edge.
  task automatic step(input logic en);
    bit e_le;
    CNT_EN = en;
    @(negedge CP_14M);
    e_le = en && (pos == 64);
    chk("dut60.LINE_END", 32'(le60), 32'(e_le));
    chk("dut50.LINE_END", 32'(le50), 32'(e_le));
    chk("dut60.FRAME_END", 32'(fe60), 32'(e_le && l60 == 261));
    chk("dut50.FRAME_END", 32'(fe50), 32'(e_le && l50 == 311));
    n_le60 += int'(le60);
    n_fe60 += int'(fe60);
    n_fe50 += int'(fe50);
    @(posedge CP_14M);
    #1;
    if (en) begin
      counted = 1;
      n_cnt++;
      if (pos == 64) begin
        pos = 0;
        l60 = (l60 + 1) % 262;
        l50 = (l50 + 1) % 312;
      end else begin
        pos++;
      end
      if (blank60 === 1'b0) n_vis++;
    end
    check_state();
  endtask

  initial begin
    bit en;
    CLR = 1'b1;
    CNT_EN = 1'b0;
    model_reset();

    // Reset holds regardless of CNT_EN activity.
    for (int i = 0; i < 6; i++) begin
      CNT_EN = ~CNT_EN;
      @(posedge CP_14M);
      #1;
    end
    CNT_EN = 1'b1;
    #1;
    chk("reset.LINE_END", 32'(le60), 32'd0);
    check_state();
    CLR = 1'b0;
    step(1'b0);
    step(1'b1);
    chk("first.H", 32'(h60), 32'h40);
    chk("first.HBL", 32'(hbl60), 32'd1);

    // Finish the first line.
    for (int i = 0; i < 64; i++) step(1'b1);
    chk("line.V", 32'(v60), 32'h0FB);
    chk("line.LINE_END_count", 32'(n_le60), 32'd1);

    // Slow cadence: one count every 14th clock.
    for (int i = 0; i < 400; i++) begin
      for (int j = 0; j < 13; j++) step(1'b0);
      step(1'b1);
    end

    // Randomly gapped counting through a full 50 Hz frame (covers a full 60 Hz frame).
    while (n_cnt < 20280) begin
      en = ($urandom_range(0, 7) != 0);
      step(en);
      if (en && n_cnt == 17030) begin
        chk("frame60.V", 32'(v60), 32'h0FA);
        chk("frame60.FRAME_END_count", 32'(n_fe60), 32'd1);
        chk("frame60.visible", 32'(n_vis), 32'd7680);
      end
    end
    chk("frame50.H", 32'(h50), 32'h00);
    chk("frame50.V", 32'(v50), 32'h0C8);
    chk("frame50.FRAME_END_count", 32'(n_fe50), 32'd1);
    chk("frame50.LINE_END_count", 32'(n_le60), 32'd312);

    // Re-reset, then run to H=6A, V=150 and pulse CLR asynchronously mid-strobe.
    CLR = 1'b1;
    @(posedge CP_14M);
    #1;
    CLR = 1'b0;
    model_reset();
    for (int i = 0; i < 86 * 65 + 43; i++) step(1'b1);
    chk("midline.H", 32'(h60), 32'h6A);
    chk("midline.V", 32'(v60), 32'h150);
    CNT_EN = 1'b1;
    #2;
    CLR = 1'b1;
    #1;
    model_reset();
    check_state();
    @(posedge CP_14M);
    #1;
    CLR = 1'b0;
    check_state();
    step(1'b1);
    chk("restart.H", 32'(h60), 32'h40);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
